// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signal bundle between the requesting masters and the AHB bus arbiter.
// The master modport is the requester/bus side; the slave modport is the arbiter itself.
interface ahb_bus_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 4
);

   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic                   hready;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [3:0]             hmaster;
   logic                   hmastlock;

   modport master (
      output hbusreq,
      output hlock,
      output hready,
      input  hgrant,
      input  hmaster,
      input  hmastlock
   );

   modport slave (
      input  hbusreq,
      input  hlock,
      input  hready,
      output hgrant,
      output hmaster,
      output hmastlock
   );

endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with locked transfers, bounded tenure and default-master parking.
// hgrant follows the owner decided at each hready-high edge; hmaster/hmastlock follow one
// hready-qualified cycle later to mirror the AHB address-phase handover.
module ahb_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned DEFAULT_MASTER = 0,
   parameter int unsigned MAX_TENURE     = 8
) (
   input logic              hclk,
   input logic              hreset,
   ahb_bus_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned TEN_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
   localparam int          NM    = int'(NUM_MASTERS);

   localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
   localparam logic [TEN_W-1:0]       TEN_LAST  = TEN_W'(MAX_TENURE - 1);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic [0:0] {
      StPark,
      StOwn
   } state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [TEN_W-1:0]       tenure_q, tenure_d;
   logic                   lock_q, lock_d;
   logic [NUM_MASTERS-1:0] hgrant_q;
   logic [3:0]             hmaster_q;
   logic                   hmastlock_q;

   logic                   owner_req;
   logic                   owner_lock;
   logic                   others_req;
   logic [NUM_MASTERS-1:0] others_mask;
   logic [IDX_W-1:0]       next_idx;
   logic [IDX_W-1:0]       scan_idx;
   logic                   scan_found;
   logic                   tenure_left;

   // Classify the current requests relative to the owner.
   always_comb begin
      owner_req            = bus.hbusreq[owner_q];
      owner_lock           = owner_req & bus.hlock[owner_q];
      others_mask          = bus.hbusreq;
      others_mask[owner_q] = 1'b0;
      others_req           = |others_mask;
      tenure_left          = (tenure_q < TEN_LAST);
   end

   // Round-robin scan: first requester after the owner, wrapping at NUM_MASTERS-1 -> 0.
   always_comb begin
      next_idx   = owner_q;
      scan_idx   = owner_q;
      scan_found = 1'b0;
      for (int k = 1; k < NM; k++) begin
         scan_idx = IDX_W'((int'(owner_q) + k) % NM);
         if (!scan_found && bus.hbusreq[scan_idx]) begin
            scan_found = 1'b1;
            next_idx   = scan_idx;
         end
      end
   end

   // Arbitration decision, first matching rule wins.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      tenure_d = tenure_q;
      if (owner_lock) begin
         // Locked ownership is never preempted; tenure does not advance.
         state_d = StOwn;
      end else if (owner_req && !others_req) begin
         state_d = StOwn;
         if (tenure_left) begin
            tenure_d = tenure_q + 1'b1;
         end
      end else if (owner_req && tenure_left) begin
         state_d  = StOwn;
         tenure_d = tenure_q + 1'b1;
      end else if (others_req) begin
         state_d  = StOwn;
         owner_d  = next_idx;
         tenure_d = '0;
      end else begin
         state_d  = StPark;
         owner_d  = DEF_IDX;
         tenure_d = '0;
      end
      // hlock only counts together with the matching request.
      lock_d = bus.hbusreq[owner_d] & bus.hlock[owner_d];
   end

   // Arbiter state and registered outputs; everything holds while hready is low.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q     <= StPark;
         owner_q     <= DEF_IDX;
         tenure_q    <= '0;
         lock_q      <= 1'b0;
         hgrant_q    <= DEF_GRANT;
         hmaster_q   <= 4'(DEF_IDX);
         hmastlock_q <= 1'b0;
      end else if (bus.hready) begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         tenure_q    <= tenure_d;
         lock_q      <= lock_d;
         hgrant_q    <= NUM_MASTERS'(1) << owner_d;
         // Address phase follows the grant issued on the previous qualified cycle.
         hmaster_q   <= 4'(owner_q);
         hmastlock_q <= lock_q;
      end
   end

   assign bus.hgrant    = hgrant_q;
   assign bus.hmaster   = hmaster_q;
   assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed per-cycle vectors push hand-computed
// expectations; a monitor pops and compares after every clock edge or reset assertion.
module tb_ahb_bus_arbiter;

   typedef struct packed {
      logic [3:0] grant;
      logic [3:0] master;
      logic       lock;
   } exp_t;

   logic hclk   = 1'b0;
   logic hreset = 1'b1;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks   = 0;
   int    failures = 0;

   ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

   ahb_bus_arbiter #(
      .NUM_MASTERS   (4),
      .DEFAULT_MASTER(0),
      .MAX_TENURE    (8)
   ) dut (
      .hclk  (hclk),
      .hreset(hreset),
      .bus   (bus)
   );

   always #5 hclk = ~hclk;

   // Drive one cycle of inputs at the falling edge; expectation is for after the next rise.
   task automatic cyc(input logic [3:0] req, input logic [3:0] lck, input logic rdy,
                      input logic [3:0] eg, input logic [3:0] em, input logic el,
                      input string nm);
      exp_t e;
      @(negedge hclk);
      bus.hbusreq = req;
      bus.hlock   = lck;
      bus.hready  = rdy;
      e.grant     = eg;
      e.master    = em;
      e.lock      = el;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compares against the oldest expectation after each edge or reset assertion.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge hclk or posedge hreset);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (bus.hgrant !== e.grant || bus.hmaster !== e.master ||
                bus.hmastlock !== e.lock) begin
               failures++;
               $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmastlock=%b",
                        nm, bus.hgrant, bus.hmaster, bus.hmastlock, e.grant, e.master, e.lock);
            end
         end
      end
   end

   initial begin
      exp_t e;
      logic [3:0] g;
      bus.hbusreq = '0;
      bus.hlock   = '0;
      bus.hready  = 1'b1;

      // Reset state while reset is held, then release and stay parked.
      cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "reset_hold");
      @(negedge hclk);
      hreset = 1'b0;
      for (int i = 0; i < 20; i++) cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "park");
      // hlock without hbusreq is ignored.
      cyc(4'b0000, 4'b1011, 1'b1, 4'b0001, 4'd0, 1'b0, "lock_no_req");
      cyc(4'b0000, 4'b1011, 1'b1, 4'b0001, 4'd0, 1'b0, "lock_no_req");

      // Single request: grant after 1 cycle, hmaster after 2, release back to default.
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd0, 1'b0, "single_grant");
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2, 1'b0, "single_master");
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2, 1'b0, "single_hold");
      cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd2, 1'b0, "single_drop");
      cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "single_park");

      // Locked tenure: master 1 locked for 20 cycles while master 3 waits.
      cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, 4'd0, 1'b0, "lock_grant");
      for (int i = 0; i < 19; i++) cyc(4'b1010, 4'b0010, 1'b1, 4'b0010, 4'd1, 1'b1, "lock_hold");
      cyc(4'b1010, 4'b0000, 1'b1, 4'b0010, 4'd1, 1'b1, "unlock_1");
      for (int i = 0; i < 6; i++) cyc(4'b1010, 4'b0000, 1'b1, 4'b0010, 4'd1, 1'b0, "unlock_tenure");
      cyc(4'b1010, 4'b0000, 1'b1, 4'b1000, 4'd1, 1'b0, "unlock_handover");
      cyc(4'b1010, 4'b0000, 1'b1, 4'b1000, 4'd3, 1'b0, "unlock_master");
      cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd3, 1'b0, "unlock_park");
      cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "unlock_park2");

      // Wait states: pending handover frozen while hready is low.
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd0, 1'b0, "wait_grant");
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2, 1'b0, "wait_master");
      cyc(4'b0001, 4'b0000, 1'b0, 4'b0100, 4'd2, 1'b0, "wait_hold");
      cyc(4'b1011, 4'b0001, 1'b0, 4'b0100, 4'd2, 1'b0, "wait_hold");
      cyc(4'b0000, 4'b0000, 1'b0, 4'b0100, 4'd2, 1'b0, "wait_hold");
      cyc(4'b1001, 4'b0000, 1'b0, 4'b0100, 4'd2, 1'b0, "wait_hold");
      cyc(4'b0001, 4'b0000, 1'b0, 4'b0100, 4'd2, 1'b0, "wait_hold");
      cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'd2, 1'b0, "wait_release");
      cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "wait_master");
      cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "rr_park");

      // Round robin with all requesting: master 0 keeps 7 more cycles, then 8 each.
      for (int c = 0; c < 7; c++) cyc(4'b1111, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "rr_first");
      for (int i = 1; i < 8; i++) begin
         g = 4'b0001 << (i % 4);
         cyc(4'b1111, 4'b0000, 1'b1, g, 4'((i - 1) % 4), 1'b0, "rr_handover");
         for (int c = 1; c < 8; c++) begin
            if (i == 2 && c == 3) begin
               // Tenure must not advance across wait states.
               for (int w = 0; w < 3; w++)
                  cyc(4'b1111, 4'b0000, 1'b0, g, 4'(i % 4), 1'b0, "rr_wait");
            end
            cyc(4'b1111, 4'b0000, 1'b1, g, 4'(i % 4), 1'b0, "rr_tenure");
         end
      end

      // Wrap-around: owner 3 expired, requests 1001 -> master 0.
      cyc(4'b1001, 4'b0000, 1'b1, 4'b0001, 4'd3, 1'b0, "wrap_grant");
      cyc(4'b1001, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "wrap_master");

      // Reset mid-tenure of master 2 aborts immediately.
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd0, 1'b0, "pre_reset_grant");
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2, 1'b0, "pre_reset_master");
      @(negedge hclk);
      e.grant  = 4'b0001;
      e.master = 4'd0;
      e.lock   = 1'b0;
      exp_q.push_back(e);
      name_q.push_back("reset_async");
      hreset = 1'b1;
      cyc(4'b0100, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "reset_mid");
      @(negedge hclk);
      bus.hbusreq = '0;
      bus.hlock   = '0;
      hreset      = 1'b0;
      for (int i = 0; i < 20; i++) cyc(4'b0000, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0, "park_after");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge hclk);
      #2;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter sharing one AHB bus among up to NUM_MASTERS master interfaces.
- Each master interface raises hbusreq when its master module asserts hbusreq_in/enable.
- Drives one-hot hgrant plus address-phase hmaster/hmastlock, consumed by the address/control mux and the slave decoder.
- Supports locked transfers, bounded tenure for fairness, and parking on a default master when the bus is idle.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; legal range 2..16.
- DEFAULT_MASTER, 0, master index that owns the bus after reset and when no master requests.
- MAX_TENURE, 8, hready-qualified cycles the owner keeps the bus while another master waits; legal range ≥1.

Ports:
- hclk  input  1  bus clock; all state updates on the rising edge.
- hreset  input  1  asynchronous, active-high reset.
- hbusreq  input  NUM_MASTERS  per-master bus request; bit i belongs to master i.
- hlock  input  NUM_MASTERS  per-master locked-transfer request; only meaningful with the matching hbusreq bit.
- hready  input  1  bus-wide transfer-done from the slave mux; arbitration advances only when high.
- hgrant  output  NUM_MASTERS  one-hot grant, registered.
- hmaster  output  4  index of the address-phase owner, registered, zero-extended.
- hmastlock  output  1  current address-phase transfer is locked, registered.

Behaviour:
- Reset (hreset=1, asynchronous):
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = DEFAULT_MASTER; hmastlock = 0.
  - Internal owner = DEFAULT_MASTER; tenure counter = 0; state = PARK.
  - Reset asserted mid-tenure aborts the grant immediately; no cycle is needed to finish it.
- States:
  - PARK: owner = DEFAULT_MASTER, not requesting.
  - OWN: owner is requesting.
- Evaluation: at each rising edge with hready=1, evaluate in priority order (first match wins):
  1. hbusreq[owner]=1 and hlock[owner]=1: keep owner; tenure holds. Locked ownership is never preempted.
  2. hbusreq[owner]=1 and no other request: keep owner; tenure saturates at MAX_TENURE-1.
  3. hbusreq[owner]=1, another request pending, tenure < MAX_TENURE-1: keep owner; tenure+1.
  4. Any hbusreq[j]=1 with j≠owner:
     - New owner = first requesting index scanning owner+1, owner+2, … modulo NUM_MASTERS.
     - Tenure = 0; state = OWN.
  5. Only hbusreq[owner]=1 is not applicable here, because rule 2 already covers it.
  6. No request at all: owner = DEFAULT_MASTER; tenure = 0; state = PARK.
- Output timing:
  - hgrant reflects the new owner one cycle after the deciding edge; this is the registered grant.
  - hmaster and hmastlock update only on edges with hready=1, to the owner/hlock[owner] value granted on the previous cycle. hmaster therefore lags hgrant by one hready-qualified cycle, per the AHB address-phase handover.
- hready=0: hgrant, hmaster, hmastlock, owner and tenure all hold, whatever the requests do (wait-stated transfers are never re-arbitrated).
- The owner dropping hbusreq while others wait hands over on the next hready-high edge; tenure is irrelevant.
- Only DEFAULT_MASTER requesting while parked: moves to OWN with the same owner; hgrant is unchanged.
- Request bits at index ≥ NUM_MASTERS do not exist. The index scan wraps at NUM_MASTERS-1 → 0.
- hgrant is exactly one-hot in every cycle after reset; it is never zero and never multi-hot.
- hlock asserted without the matching hbusreq is ignored.
- Latency: request to hgrant is 1 cycle minimum when the bus is free; request to hmaster is 2 cycles with hready=1 throughout.

Test Plan:
- Reset/park: assert hreset mid-run, no requests → hgrant=4'b0001, hmaster=0, hmastlock=0 immediately and after release; stays parked for 20 cycles.
- Single request: hbusreq=4'b0100, hready=1 → hgrant=4'b0100 after 1 cycle, hmaster=2 after 2 cycles; hbusreq drops → hgrant=4'b0001 next cycle.
- Round-robin fairness: hbusreq=4'b1111 constant, hready=1, MAX_TENURE=8 → grant order 1,2,3,0,1… with each grant held exactly 8 cycles; no master is starved.
- Locked tenure: master 1 holds hbusreq+hlock for 20 cycles while master 3 requests → hgrant=4'b0010 for all 20 cycles and hmastlock=1; hlock drop → master 3 granted within MAX_TENURE cycles.
- Wait states: handover pending while hready=0 for 5 cycles → hgrant, hmaster and tenure frozen; the handover occurs on the first hready=1 edge.
- Wrap-around scan: owner=3, hbusreq=4'b1001, tenure expired → next owner 0 (not 3); hmaster=0 one hready-cycle after hgrant=4'b0001.
